// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the handshaked data-memory responder.
// Access sizes, FSM states and byte-count/mask helpers live here.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Low-aligned mask covering the bytes of one access of the given size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00ff;
      SZ_H:    return 64'h0000_0000_0000_ffff;
      SZ_W:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed bytes out of a little-endian doubleword and
// sign- or zero-extends them to 64 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [63:0] shifted;
  logic [63:0] mask;
  logic [63:0] raw;
  logic        sign;

  always_comb begin
    shifted = dword >> {offset, 3'b000};
    mask    = size_mask(size);
    raw     = shifted & mask;
    case (size)
      SZ_B:    sign = raw[7];
      SZ_H:    sign = raw[15];
      SZ_W:    sign = raw[31];
      default: sign = 1'b0;
    endcase
    data = (sign && !is_unsigned) ? (raw | ~mask) : raw;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle request/response data memory: one outstanding access, loads
// sampled and stores committed on the edge that enters RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] ele1,
  output logic [63:0] ele2,
  output logic [63:0] ele3,
  output logic [63:0] ele4,
  output logic [63:0] ele5
);

  localparam int NDW = DEPTH_BYTES / 8;
  localparam int CW  = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the responder holds rsp_* stable while rsp_valid waits.
  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          accept, enter_resp;

  logic          lat_we, lat_uns;
  logic [1:0]    lat_size;
  logic [63:0]   lat_addr, lat_wdata;
  logic          cur_we, cur_uns;
  logic [1:0]    cur_size;
  logic [63:0]   cur_addr, cur_wdata;

  logic [63:0]   mem [NDW];
  logic [63:0]   rd_dword, ld_data, st_mask, st_data;
  logic [64:0]   end_addr;
  logic [2:0]    align_mask;
  logic          misaligned, out_of_range, acc_err;
  logic [63:0]   ele_w [5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (accept)
        cnt <= CW'(LATENCY);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    accept     = req_ready && req_valid;
    enter_resp = (state != RESP) && (next_state == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= SZ_B;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_uns   <= req_unsigned;
      lat_size  <= req_size;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // With zero latency the access completes on the accepting edge, so the
  // live request is used directly while idle.
  always_comb begin
    cur_we    = (state == IDLE) ? req_we       : lat_we;
    cur_uns   = (state == IDLE) ? req_unsigned : lat_uns;
    cur_size  = (state == IDLE) ? req_size     : lat_size;
    cur_addr  = (state == IDLE) ? req_addr     : lat_addr;
    cur_wdata = (state == IDLE) ? req_wdata    : lat_wdata;
  end

  always_comb begin
    align_mask   = 3'(size_bytes(cur_size) - 4'd1);
    misaligned   = (cur_addr[2:0] & align_mask) != 3'd0;
    end_addr     = {1'b0, cur_addr} + {61'd0, size_bytes(cur_size)};
    out_of_range = end_addr > 65'(DEPTH_BYTES);
    acc_err      = misaligned | out_of_range;
    st_mask      = size_mask(cur_size) << {cur_addr[2:0], 3'b000};
    st_data      = cur_wdata << {cur_addr[2:0], 3'b000};
  end

  always_comb begin
    rd_dword = '0;
    for (int i = 0; i < NDW; i++)
      if (cur_addr[63:3] == 61'(i)) rd_dword = mem[i];
  end

  dmem_load_align u_align (
    .dword       (rd_dword),
    .offset      (cur_addr[2:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .data        (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDW; i++) mem[i] <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || cur_we) ? '0 : ld_data;
      if (cur_we && !acc_err)
        for (int i = 0; i < NDW; i++)
          if (cur_addr[63:3] == 61'(i))
            mem[i] <= (mem[i] & ~st_mask) | (st_data & st_mask);
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_ele
    if (g < NDW) begin : g_map
      assign ele_w[g] = mem[g];
    end else begin : g_zero
      assign ele_w[g] = '0;
    end
  end

  assign ele1 = ele_w[0];
  assign ele2 = ele_w[1];
  assign ele3 = ele_w[2];
  assign ele4 = ele_w[3];
  assign ele5 = ele_w[4];

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a byte-array model predicts
// every response; a LATENCY=0 instance exercises back-to-back throughput.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 0;
  logic rst = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        rsp_ready = 1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata, ele1, ele2, ele3, ele4, ele5;

  logic        req_valid0 = 0, req_we0 = 0, req_unsigned0 = 0;
  logic [1:0]  req_size0 = 0;
  logic [63:0] req_addr0 = 0, req_wdata0 = 0;
  logic        rsp_ready0 = 1;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [63:0] rsp_rdata0, e0_1, e0_2, e0_3, e0_4, e0_5;

  logic        rdy_rand = 1, rdy_force = 1;
  logic [7:0]  ref_mem [2][DEPTH];
  logic [64:0] exp_q[$];
  logic [64:0] exp0_q[$];
  int          acc_q[$];
  int          acc0_q[$];

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ele1(ele1), .ele2(ele2), .ele3(ele3), .ele4(ele4), .ele5(ele5)
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_size(req_size0), .req_unsigned(req_unsigned0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .ele1(e0_1), .ele2(e0_2), .ele3(e0_3), .ele4(e0_4), .ele5(e0_5)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte array, size rules applied with plain arithmetic.
  function automatic logic [64:0] model(input int w, input bit we, input logic [1:0] size,
                                        input bit uns, input logic [63:0] addr,
                                        input logic [63:0] wdata);
    int nb;
    int a;
    logic [63:0] v;
    nb = 1 << size;
    if ((addr % 64'(nb)) != 0 || addr > 64'(DEPTH - nb)) return {1'b1, 64'd0};
    a = int'(addr);
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[w][a + i] = wdata[8*i +: 8];
      return 65'd0;
    end
    v = 0;
    for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[w][a + i]) << (8 * i));
    if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return {1'b0, v};
  endfunction

  function automatic logic [63:0] ref_dword(input int w, input int k);
    logic [63:0] v = 0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[w][8*k + i]) << (8 * i));
    return v;
  endfunction

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < DEPTH; i++) ref_mem[w][i] = 8'h00;
  endtask

  // Driver tasks
  task automatic send(input bit we, input logic [1:0] size, input bit uns,
                      input logic [63:0] addr, input logic [63:0] wdata);
    int t = 0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b, expected 1", req_ready);
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model(0, we, size, uns, addr, wdata));
    acc_q.push_back(cyc);
    req_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 500) begin @(posedge clk); #1; t++; end
    check("drain_timeout", 65'(t >= 500), 65'd0);
  endtask

  task automatic check_ele(input string tag);
    check({tag, "_ele1"}, {1'b0, ele1}, {1'b0, ref_dword(0, 0)});
    check({tag, "_ele2"}, {1'b0, ele2}, {1'b0, ref_dword(0, 1)});
    check({tag, "_ele3"}, {1'b0, ele3}, {1'b0, ref_dword(0, 2)});
    check({tag, "_ele4"}, {1'b0, ele4}, {1'b0, ref_dword(0, 3)});
    check({tag, "_ele5"}, {1'b0, ele5}, {1'b0, ref_dword(0, 4)});
  endtask

  task automatic rand_req(output bit we, output logic [1:0] size, output bit uns,
                          output logic [63:0] addr, output logic [63:0] wdata);
    int r;
    we    = $urandom_range(0, 1);
    size  = 2'($urandom_range(0, 3));
    uns   = $urandom_range(0, 1);
    wdata = {$urandom, $urandom};
    r     = $urandom_range(0, 9);
    if (r == 0)      addr = 64'hffff_ffff_ffff_ffff;
    else if (r == 1) addr = 64'($urandom_range(0, 70));
    else             addr = 64'($urandom_range(0, DEPTH - 1)) & ~((64'd1 << size) - 64'd1);
  endtask

  // Scoreboard monitors
  logic        prev_v = 0, prev_v0 = 0;
  logic [64:0] held;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
    end else begin
      if (rsp_valid) begin
        check("req_ready_in_resp", 65'(req_ready), 65'd0);
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
          end else begin
            check("rsp_data", {rsp_err, rsp_rdata}, exp_q.pop_front());
            check("rsp_latency", 65'(cyc - acc_q.pop_front()), 65'(LAT + 1));
          end
          held = {rsp_err, rsp_rdata};
        end else begin
          check("rsp_hold", {rsp_err, rsp_rdata}, held);
        end
      end
      prev_v = rsp_valid;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_v0 = 0;
    end else begin
      if (rsp_valid0) begin
        check("rsp0_one_cycle", 65'(prev_v0), 65'd0);
        if (exp0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp0: rdata=%h err=%b, expected no response", rsp_rdata0, rsp_err0);
        end else begin
          check("rsp0_data", {rsp_err0, rsp_rdata0}, exp0_q.pop_front());
          check("rsp0_latency", 65'(cyc - acc0_q.pop_front()), 65'd0);
        end
      end
      prev_v0 = rsp_valid0;
    end
  end

  initial begin
    bit we, uns;
    logic [1:0] size;
    logic [63:0] addr, wdata;
    int t, last;

    clear_model();
    #1 rst = 1;
    #4;
    check("rst_req_ready", 65'(req_ready), 65'd1);
    check("rst_rsp_valid", 65'(rsp_valid), 65'd0);
    check("rst_rsp", {rsp_err, rsp_rdata}, 65'd0);
    check_ele("rst");
    @(posedge clk); @(posedge clk); #1 rst = 0;

    // Store double, signed/unsigned byte loads
    send(1, 2'b11, 0, 64'd0, 64'h1122_3344_5566_7788);
    wait_done();
    check_ele("store_d");
    send(0, 2'b00, 0, 64'd7, 64'd0);
    send(1, 2'b00, 0, 64'd8, 64'h80);
    send(0, 2'b00, 0, 64'd8, 64'd0);
    send(0, 2'b00, 1, 64'd8, 64'd0);
    // Misaligned and out-of-range accesses
    send(0, 2'b10, 0, 64'd2, 64'd0);
    send(1, 2'b11, 0, 64'd60, 64'hffff_ffff_ffff_ffff);
    send(1, 2'b00, 0, 64'hffff_ffff_ffff_ffff, 64'h55);
    wait_done();
    check_ele("errors");

    // Response stall with rsp_ready low
    rdy_rand = 0; rdy_force = 0;
    send(0, 2'b11, 0, 64'd0, 64'd0);
    t = 0;
    while (!rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("stall_rsp_seen", 65'(rsp_valid), 65'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_req_ready", 65'(req_ready), 65'd0);
      check("stall_rsp_valid", 65'(rsp_valid), 65'd1);
    end
    rdy_force = 1;
    @(posedge clk); #1;
    check("release_req_ready", 65'(req_ready), 65'd1);
    check("release_rsp_valid", 65'(rsp_valid), 65'd0);
    rdy_rand = 1;

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      rand_req(we, size, uns, addr, wdata);
      send(we, size, uns, addr, wdata);
    end
    wait_done();
    check_ele("random");
    for (int k = 0; k < 5; k++) send(1, 2'b11, 0, 64'(8 * k), {$urandom, $urandom});
    wait_done();
    check_ele("fill");

    // Asynchronous reset during the WAIT of a store
    req_we = 1; req_size = 2'b11; req_unsigned = 0; req_addr = 64'd16; req_wdata = 64'hdead;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    clear_model();
    check("arst_req_ready", 65'(req_ready), 65'd1);
    check("arst_rsp_valid", 65'(rsp_valid), 65'd0);
    check("arst_rsp", {rsp_err, rsp_rdata}, 65'd0);
    check("arst_ele3", {1'b0, ele3}, 65'd0);
    check_ele("arst");
    @(posedge clk); @(posedge clk); #1 rst = 0;
    send(0, 2'b11, 0, 64'd16, 64'd0);
    wait_done();
    check_ele("post_rst");

    // Zero-latency instance: back-to-back accepted requests
    last = 0;
    for (int k = 0; k < 30; k++) begin
      rand_req(we, size, uns, addr, wdata);
      req_we0 = we; req_size0 = size; req_unsigned0 = uns; req_addr0 = addr; req_wdata0 = wdata;
      req_valid0 = 1;
      t = 0;
      while (!req_ready0 && t < 10) begin @(posedge clk); #1; t++; end
      check("b2b_accept_wait", 65'(t), 65'(k == 0 ? 0 : 1));
      @(posedge clk); #1;
      exp0_q.push_back(model(1, we, size, uns, addr, wdata));
      acc0_q.push_back(cyc);
      if (k > 0) check("b2b_spacing", 65'(cyc - last), 65'd2);
      last = cyc;
    end
    req_valid0 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_drained", 65'(exp0_q.size()), 65'd0);
    check("b2b_ele1", {1'b0, e0_1}, {1'b0, ref_dword(1, 0)});
    check("b2b_ele5", {1'b0, e0_5}, {1'b0, ref_dword(1, 4)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "global timeout");
  end

endmodule
